// File: rtl/exec_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle execute sequencer: state codes,
// alu op codes, the PC increment and the alu control bundle.
package exec_mc_ctrl_pkg;

  // Sequencer states (3-bit, legacy-compatible encoding)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INC  = 3'd1;
  localparam logic [2:0] ST_OP   = 3'd2;
  localparam logic [2:0] ST_BR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // PC increment applied to every instruction
  localparam logic [15:0] PC_STEP = 16'd2;

  // Alu op codes; add and subtract share the adder, subtract via invB/cin
  localparam logic [2:0] AND_OP = 3'b000;
  localparam logic [2:0] SUB_OP = 3'b001;
  localparam logic [2:0] OR_OP  = 3'b010;
  localparam logic [2:0] XOR_OP = 3'b011;
  localparam logic [2:0] ADD_OP = 3'b100;
  localparam logic [2:0] SLL_OP = 3'b101;
  localparam logic [2:0] SRL_OP = 3'b110;
  localparam logic [2:0] SRA_OP = 3'b111;

  // Operand and control bundle driven into the shared alu each cycle
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        cin;
    logic        invB;
    logic        sign;
  } alu_ctrl_t;

  // Subtract is the only instruction op that needs B inverted plus carry-in
  function automatic logic isSub(input logic [2:0] op);
    return (op == SUB_OP);
  endfunction

endpackage

// File: rtl/exec_mc_ctrl_alu.sv
// 16-bit alu shared by the execute sequencer. The adder serves ADD_OP and
// SUB_OP; ofl is unsigned carry-out when sign_i=0, two's-complement
// overflow when sign_i=1. Logic and shift ops never report overflow.
module exec_mc_ctrl_alu
  import exec_mc_ctrl_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        cin_i,
  input  logic        invB_i,
  input  logic        sign_i,
  output logic [15:0] out_o,
  output logic        ofl_o
);

  logic [15:0] bx;
  logic [16:0] sum17;

  // Combinational result select and overflow detection
  always_comb begin
    bx    = invB_i ? ~b_i : b_i;
    sum17 = {1'b0, a_i} + {1'b0, bx} + {16'd0, cin_i};
    out_o = sum17[15:0];
    ofl_o = 1'b0;
    case (op_i)
      ADD_OP, SUB_OP: begin
        out_o = sum17[15:0];
        if (sign_i) begin
          ofl_o = (a_i[15] == bx[15]) && (sum17[15] != a_i[15]);
        end else begin
          ofl_o = sum17[16];
        end
      end
      AND_OP:  out_o = a_i & b_i;
      OR_OP:   out_o = a_i | b_i;
      XOR_OP:  out_o = a_i ^ b_i;
      SLL_OP:  out_o = a_i << b_i[3:0];
      SRL_OP:  out_o = a_i >> b_i[3:0];
      SRA_OP:  out_o = $signed(a_i) >>> b_i[3:0];
      default: out_o = sum17[15:0];
    endcase
  end

endmodule

// File: rtl/exec_mc_ctrl.sv
// Multi-cycle execute sequencer: one alu time-shared across PC+2, the
// instruction op and the branch-target add, handing read_addr/PC_curr/err
// to the memory stage with a valid/ready handshake.
module exec_mc_ctrl
  import exec_mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] read1data,
  input  logic [15:0] read2data,
  input  logic [15:0] sign_ext,
  input  logic [15:0] PC_old,
  input  logic [2:0]  alu_op,
  input  logic        br_ju_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] read_addr,
  output logic [15:0] PC_curr,
  output logic        err
);

  logic [2:0]  state_q,    state_d;
  logic [15:0] r1_q,       r1_d;
  logic [15:0] r2_q,       r2_d;
  logic [15:0] sext_q,     sext_d;
  logic [15:0] pc_q,       pc_d;
  logic [2:0]  op_q,       op_d;
  logic        br_q,       br_d;
  logic [15:0] pcInc_q,    pcInc_d;
  logic [15:0] readAddr_q, readAddr_d;
  logic [15:0] pcCurr_q,   pcCurr_d;
  logic        err_q,      err_d;

  alu_ctrl_t   aluCtl;
  logic [15:0] aluOut;
  logic        aluOfl;

  exec_mc_ctrl_alu uAlu (
    .a_i    (aluCtl.a),
    .b_i    (aluCtl.b),
    .op_i   (aluCtl.op),
    .cin_i  (aluCtl.cin),
    .invB_i (aluCtl.invB),
    .sign_i (aluCtl.sign),
    .out_o  (aluOut),
    .ofl_o  (aluOfl)
  );

  // Steer latched operands into the shared alu according to the current step
  always_comb begin
    aluCtl = '{a: 16'd0, b: 16'd0, op: ADD_OP, cin: 1'b0, invB: 1'b0, sign: 1'b0};
    case (state_q)
      ST_INC: begin
        aluCtl.a  = pc_q;
        aluCtl.b  = PC_STEP;
        aluCtl.op = ADD_OP;
      end
      ST_OP: begin
        aluCtl.a    = r1_q;
        aluCtl.b    = r2_q;
        aluCtl.op   = op_q;
        aluCtl.cin  = isSub(op_q);
        aluCtl.invB = isSub(op_q);
        aluCtl.sign = r2_q[15];
      end
      ST_BR: begin
        aluCtl.a    = pcInc_q;
        aluCtl.b    = sext_q;
        aluCtl.op   = ADD_OP;
        aluCtl.sign = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and result capture; flush abandons the instruction
  always_comb begin
    state_d    = state_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    sext_d     = sext_q;
    pc_d       = pc_q;
    op_d       = op_q;
    br_d       = br_q;
    pcInc_d    = pcInc_q;
    readAddr_d = readAddr_q;
    pcCurr_d   = pcCurr_q;
    err_d      = err_q;
    if (flush) begin
      state_d    = ST_IDLE;
      readAddr_d = 16'd0;
      pcCurr_d   = 16'd0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            r1_d    = read1data;
            r2_d    = read2data;
            sext_d  = sign_ext;
            pc_d    = PC_old;
            op_d    = alu_op;
            br_d    = br_ju_en;
            err_d   = 1'b0;
            state_d = ST_INC;
          end
        end
        ST_INC: begin
          pcInc_d = aluOut;
          err_d   = err_q | aluOfl;
          state_d = ST_OP;
        end
        ST_OP: begin
          readAddr_d = aluOut;
          if (br_q) begin
            state_d = ST_BR;
          end else begin
            pcCurr_d = pcInc_q;
            state_d  = ST_DONE;
          end
        end
        ST_BR: begin
          pcCurr_d = aluOut;
          err_d    = err_q | aluOfl;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      r1_q       <= 16'd0;
      r2_q       <= 16'd0;
      sext_q     <= 16'd0;
      pc_q       <= 16'd0;
      op_q       <= 3'd0;
      br_q       <= 1'b0;
      pcInc_q    <= 16'd0;
      readAddr_q <= 16'd0;
      pcCurr_q   <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      sext_q     <= sext_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      br_q       <= br_d;
      pcInc_q    <= pcInc_d;
      readAddr_q <= readAddr_d;
      pcCurr_q   <= pcCurr_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign read_addr = readAddr_q;
  assign PC_curr   = pcCurr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_exec_mc_ctrl.sv
// Self-checking bench for exec_mc_ctrl: directed vector table, hand-written
// backpressure/flush sequences and randomized instructions against a
// behavioural model.
module tb_exec_mc_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] read1data;
  logic [15:0] read2data;
  logic [15:0] sign_ext;
  logic [15:0] PC_old;
  logic [2:0]  alu_op;
  logic        br_ju_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] read_addr;
  logic [15:0] PC_curr;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] sext;
    logic [2:0]  op;
    logic        br;
    logic [15:0] expRead;
    logic [15:0] expPc;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs [6];

  exec_mc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .read1data (read1data),
    .read2data (read2data),
    .sign_ext  (sign_ext),
    .PC_old    (PC_old),
    .alu_op    (alu_op),
    .br_ju_en  (br_ju_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .read_addr (read_addr),
    .PC_curr   (PC_curr),
    .err       (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one instruction's fields onto the decode-side ports
  task automatic applyStimulus(input vec_t v, input logic valid);
    in_valid  = valid;
    PC_old    = v.pc;
    read1data = v.r1;
    read2data = v.r2;
    sign_ext  = v.sext;
    alu_op    = v.op;
    br_ju_en  = v.br;
  endtask

  // Reference model: results computed from plain arithmetic on integers
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int unsigned inc;
    logic [15:0] pcInc;
    shortint     a;
    shortint     b;
    int          s;
    r     = v;
    inc   = 32'(v.pc) + 32'd2;
    pcInc = inc[15:0];
    r.expErr = (inc > 32'd65535);
    if (v.br) begin
      a = pcInc;
      b = v.sext;
      s = int'(a) + int'(b);
      if (s > 32767 || s < -32768) r.expErr = 1'b1;
      r.expPc  = s[15:0];
      r.expLat = 3;
    end else begin
      r.expPc  = pcInc;
      r.expLat = 2;
    end
    case (v.op)
      3'b100:  r.expRead = v.r1 + v.r2;
      3'b001:  r.expRead = v.r1 - v.r2;
      3'b000:  r.expRead = v.r1 & v.r2;
      3'b010:  r.expRead = v.r1 | v.r2;
      3'b011:  r.expRead = v.r1 ^ v.r2;
      3'b101:  r.expRead = v.r1 << v.r2[3:0];
      3'b110:  r.expRead = v.r1 >> v.r2[3:0];
      default: r.expRead = $signed(v.r1) >>> v.r2[3:0];
    endcase
    return r;
  endfunction

  // Issue one instruction, scramble the inputs, then check latency and results
  task automatic runInstr(input vec_t v, input string tag, input int hold,
                          input bit checkHold);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    applyStimulus(v, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    read1data = 16'($urandom);
    read2data = 16'($urandom);
    sign_ext  = 16'($urandom);
    PC_old    = 16'($urandom);
    alu_op    = 3'($urandom);
    br_ju_en  = 1'($urandom);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'(v.expLat));
    checkOutput({tag, ".read_addr"}, 32'(read_addr), 32'(v.expRead));
    checkOutput({tag, ".PC_curr"}, 32'(PC_curr), 32'(v.expPc));
    checkOutput({tag, ".err"}, 32'(err), 32'(v.expErr));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (checkHold) begin
        checkOutput({tag, ".hold.out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".hold.in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ".hold.read_addr"}, 32'(read_addr), 32'(v.expRead));
        checkOutput({tag, ".hold.PC_curr"}, 32'(PC_curr), 32'(v.expPc));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".release.out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".release.in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    bit   sawValid;

    vecs[0] = '{16'h0010, 16'd5, 16'd7, 16'h0000, 3'b100, 1'b0,
                16'd12, 16'h0012, 1'b0, 2};
    vecs[1] = '{16'h0100, 16'd9, 16'd3, 16'hFFFC, 3'b001, 1'b1,
                16'd6, 16'h00FE, 1'b0, 3};
    vecs[2] = '{16'hFFFE, 16'd1, 16'd1, 16'h0000, 3'b100, 1'b0,
                16'd2, 16'h0000, 1'b1, 2};
    vecs[3] = '{16'h0200, 16'hF0F0, 16'h0F00, 16'h0000, 3'b010, 1'b0,
                16'hFFF0, 16'h0202, 1'b0, 2};
    vecs[4] = '{16'h7FFC, 16'h0003, 16'h0004, 16'h0010, 3'b001, 1'b1,
                16'hFFFF, 16'h800E, 1'b1, 3};
    vecs[5] = '{16'h0040, 16'hAAAA, 16'hFFFF, 16'h0002, 3'b011, 1'b1,
                16'h5555, 16'h0044, 1'b0, 3};

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(vecs[0], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.read_addr", 32'(read_addr), 32'd0);
    checkOutput("reset.PC_curr", 32'(PC_curr), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runInstr(vecs[i], $sformatf("vec%0d", i), 0, 1'b0);
    end

    runInstr(vecs[1], "backpressure", 5, 1'b1);
    runInstr(vecs[0], "afterBackpressure", 0, 1'b0);

    // Flush while the branch add is in progress, with in_valid asserted
    @(negedge clk);
    applyStimulus(vecs[5], 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flushBr.out_valid", 32'(out_valid), 32'd0);
    checkOutput("flushBr.in_ready", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("flushBr.noValid", 32'(sawValid), 32'd0);
    runInstr(vecs[3], "afterFlushBr", 0, 1'b0);

    // Flush in IDLE suppresses the accept
    @(negedge clk);
    applyStimulus(vecs[0], 1'b1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flushIdle.in_ready", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("flushIdle.noValid", 32'(sawValid), 32'd0);

    // Randomized instructions against the model
    for (int i = 0; i < 150; i++) begin
      v.pc   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                           : 16'($urandom);
      v.r1   = 16'($urandom);
      v.r2   = 16'($urandom);
      v.sext = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                           : 16'($signed(8'($urandom)));
      v.op   = 3'($urandom);
      v.br   = 1'($urandom);
      v = model(v);
      runInstr(v, $sformatf("rand%0d", i), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
